// File: rtl/fft_sample_ram.sv
// Single-clock FFT sample buffer: one byte-enabled write port, one registered read port,
// and a clear sequencer that zeroes the array. Define FFT_RAM_PARITY_EN for per-byte even parity.
module fft_sample_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [BE_W-1:0]   wr_be_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
`ifdef FFT_RAM_PARITY_EN
  input  logic              par_inj_i,
  output logic              par_err_o,
`endif
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef FFT_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + BE_W;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              wr_fire, rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [MEM_W-1:0]  rd_word;
`ifdef FFT_RAM_PARITY_EN
  logic [BE_W-1:0]   mem_wpar;
  logic [BE_W-1:0]   wr_par;
  logic              rd_err;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clear_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign busy_o  = (state_q == S_CLEAR);
  assign wr_fire = (state_q == S_IDLE) && wr_en_i;
  assign rd_fire = (state_q == S_IDLE) && rd_en_i;

`ifdef FFT_RAM_PARITY_EN
  always_comb begin
    wr_par = '0;
    for (int k = 0; k < BE_W; k++) begin
      wr_par[k] = ^wr_data_i[8*k +: 8];
    end
    wr_par[0] = wr_par[0] ^ par_inj_i;
  end
`endif

  // The clear sequencer owns the write port while busy; user traffic is dropped.
  always_comb begin
    mem_we    = wr_fire;
    mem_addr  = wr_addr_i;
    mem_be    = wr_be_i;
    mem_wdata = wr_data_i;
`ifdef FFT_RAM_PARITY_EN
    mem_wpar  = wr_par;
`endif
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
`ifdef FFT_RAM_PARITY_EN
      mem_wpar  = '0;
`endif
    end
  end

  // NOTE: the storage array has no reset; the clear sequencer zeroes it instead,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be[k]) begin
          mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
`ifdef FFT_RAM_PARITY_EN
          mem[mem_addr][DATA_W+k] <= mem_wpar[k];
`endif
        end
      end
    end
  end

  // Write-first bypass: enabled bytes of a same-address write override stored bytes.
  always_comb begin
    rd_word = mem[rd_addr_i];
    if (wr_fire && (wr_addr_i == rd_addr_i)) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be_i[k]) begin
          rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
`ifdef FFT_RAM_PARITY_EN
          rd_word[DATA_W+k] = wr_par[k];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_data_o <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef FFT_RAM_PARITY_EN
  always_comb begin
    rd_err = 1'b0;
    for (int k = 0; k < BE_W; k++) begin
      rd_err = rd_err | ((^rd_word[8*k +: 8]) ^ rd_word[DATA_W+k]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      par_err_o <= 1'b0;
    end else begin
      par_err_o <= rd_fire && rd_err;
    end
  end
`endif

endmodule

// File: tb/tb_fft_sample_ram.sv
// Randomized self-checking bench for fft_sample_ram against a word/byte-level array model.
module tb_fft_sample_ram;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear_req;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
`ifdef FFT_RAM_PARITY_EN
  logic              par_inj;
  logic              par_err;
`endif

  always #5 clk = ~clk;

  fft_sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (clear_req),
    .busy_o    (busy),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_be_i   (wr_be),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
`ifdef FFT_RAM_PARITY_EN
    .par_inj_i (par_inj),
    .par_err_o (par_err),
`endif
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid)
  );

  // Reference model: plain arrays of words and per-byte parity bits.
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [BE_W-1:0]   par_m [DEPTH];
  int                busy_left;
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid;
  logic              exp_err;
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      par_m[i] = '0;
    end
  endtask

  task automatic model_step();
    logic inj;
    inj = 1'b0;
`ifdef FFT_RAM_PARITY_EN
    inj = par_inj;
`endif
    if (busy_left > 0) begin
      busy_left--;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < BE_W; k++) begin
          if (wr_be[k]) begin
            mem_m[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            par_m[wr_addr][k] = (^wr_data[8*k +: 8]) ^ ((k == 0) && inj);
          end
        end
      end
      exp_valid = rd_en;
      exp_err   = 1'b0;
      if (rd_en) begin
        exp_data = mem_m[rd_addr];
        for (int k = 0; k < BE_W; k++) begin
          if ((^mem_m[rd_addr][8*k +: 8]) != par_m[rd_addr][k]) exp_err = 1'b1;
        end
      end
      if (clear_req) begin
        busy_left = DEPTH;
        model_zero();
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(busy_left > 0));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("rd_data", rd_data, exp_data);
`ifdef FFT_RAM_PARITY_EN
    check("par_err", 32'(par_err), 32'(exp_err));
`endif
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_be     = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
`ifdef FFT_RAM_PARITY_EN
    par_inj   = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
`ifdef FFT_RAM_PARITY_EN
    check("rst_par_err", 32'(par_err), 32'd0);
`endif
    model_zero();
    busy_left = DEPTH;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Bounded wait for busy to drop; returns number of edges observed.
  task automatic count_busy(input string tag, input int expected);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 400);
    check(tag, 32'(n), 32'(expected));
  endtask

  task automatic do_op(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [BE_W-1:0] be, input logic re, input logic [ADDR_W-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    tick();
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    apply_reset();
    count_busy("busy_len_reset", DEPTH);

    do_op(0, 0, 0, 0, 1, 8'h00);
    check("rd_zero_00", rd_data, 32'h0);
    do_op(0, 0, 0, 0, 1, 8'h7F);
    check("rd_zero_7f", rd_data, 32'h0);
    do_op(0, 0, 0, 0, 1, 8'hFF);
    check("rd_zero_ff_valid", 32'(rd_valid), 32'd1);
    tick();
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);

    do_op(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_op(1, 8'h10, 32'h11223344, 4'h5, 0, 0);
    do_op(0, 0, 0, 0, 1, 8'h10);
    check("byte_enable", rd_data, 32'hDE22BE44);
    tick();
    check("rd_hold", rd_data, 32'hDE22BE44);

    do_op(1, 8'h20, 32'hCAFEF00D, 4'hF, 1, 8'h20);
    check("write_first", rd_data, 32'hCAFEF00D);
    do_op(1, 8'h21, 32'h0000AAAA, 4'h1, 1, 8'h21);
    check("write_first_partial", rd_data, 32'h000000AA);
    do_op(1, 8'h22, 32'h55555555, 4'h0, 1, 8'h22);
    check("be_zero_no_change", rd_data, 32'h0);

    do_op(1, 8'h30, 32'h12345678, 4'hF, 0, 0);
    do_op(0, 0, 0, 0, 1, 8'h30);
    check("fill_30", rd_data, 32'h12345678);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wr_en = 1'b1; wr_addr = 8'h31; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'h30;
    count_busy("busy_len_clear", DEPTH);
    idle_inputs();
    check("rd_held_through_clear", rd_data, 32'h12345678);
    do_op(0, 0, 0, 0, 1, 8'h30);
    check("cleared_30", rd_data, 32'h0);
    do_op(0, 0, 0, 0, 1, 8'h31);
    check("dropped_31", rd_data, 32'h0);

    do_op(1, 8'h50, 32'hAA55AA55, 4'hF, 1, 8'h50);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    apply_reset();
    count_busy("busy_len_midreset", DEPTH);
    do_op(0, 0, 0, 0, 1, 8'h50);
    check("midreset_cleared", rd_data, 32'h0);

`ifdef FFT_RAM_PARITY_EN
    par_inj = 1'b1;
    do_op(1, 8'h40, 32'h000000FF, 4'hF, 0, 0);
    do_op(0, 0, 0, 0, 1, 8'h40);
    check("par_inj_err", 32'(par_err), 32'd1);
    do_op(1, 8'h41, 32'h01020307, 4'hF, 0, 0);
    do_op(0, 0, 0, 0, 1, 8'h41);
    check("par_clean", 32'(par_err), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 999) == 0);
`ifdef FFT_RAM_PARITY_EN
      par_inj = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
